// File: rtl/store_buffer_if.sv
// Store buffer port bundle: pipeline enqueue, memory write port and load lookup.
// The slave modport is the buffer side; the master modport is the pipeline/memory side.
interface store_buffer_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              enq_valid;
   logic              enq_ready;
   logic [ADDR_W-1:0] enq_addr;
   logic [DATA_W-1:0] enq_data;
   logic [9:0]        enq_funct;
   logic              mem_w_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [9:0]        mem_funct;
   logic              mem_ready;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic              ld_hit;
   logic [DATA_W-1:0] ld_data;
   logic              ld_conflict;

   modport slave (
      input  enq_valid, enq_addr, enq_data, enq_funct, mem_ready, ld_en, ld_addr,
      output enq_ready, mem_w_en, mem_addr, mem_wdata, mem_funct, ld_hit, ld_data, ld_conflict
   );

   modport master (
      output enq_valid, enq_addr, enq_data, enq_funct, mem_ready, ld_en, ld_addr,
      input  enq_ready, mem_w_en, mem_addr, mem_wdata, mem_funct, ld_hit, ld_data, ld_conflict
   );
endinterface

// File: rtl/store_buffer.sv
// In-order committed-store FIFO feeding the data-memory write port, with load forwarding/stall.
// Define STORE_BUF_COALESCE_EN to merge a word store into an identical-word youngest entry.
`ifndef FUNC_SB
`define FUNC_SB 10'h000
`endif
`ifndef FUNC_SH
`define FUNC_SH 10'h001
`endif

module store_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   store_buffer_if.slave          sb,
   output logic [$clog2(DEPTH):0] count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] e_addr  [DEPTH];
   logic [DATA_W-1:0] e_data  [DEPTH];
   logic [9:0]        e_funct [DEPTH];
   logic [DEPTH-1:0]  e_valid;
   logic [PTR_W-1:0]  head, tail, last;

   logic enq_fire, drain, alloc, coalesce;
   logic found, found_word;
   logic [DATA_W-1:0] found_data;
   logic [PTR_W-1:0]  idx;
   logic hit_cond;

   function automatic logic is_word(input logic [9:0] f);
      return (f != `FUNC_SB) && (f != `FUNC_SH);
   endfunction

   assign last         = tail - PTR_W'(1);
   assign sb.enq_ready = (count != CNT_W'(DEPTH));
   assign enq_fire     = sb.enq_valid & sb.enq_ready;
   assign sb.mem_w_en  = (count != '0);
   assign drain        = sb.mem_w_en & sb.mem_ready;
   assign sb.mem_addr  = sb.mem_w_en ? e_addr[head]  : '0;
   assign sb.mem_wdata = sb.mem_w_en ? e_data[head]  : '0;
   assign sb.mem_funct = sb.mem_w_en ? e_funct[head] : '0;

`ifdef STORE_BUF_COALESCE_EN
   // The youngest entry is excluded when it is also the head leaving this cycle.
   assign coalesce = enq_fire && is_word(sb.enq_funct) && (count != '0)
                     && is_word(e_funct[last])
                     && (e_addr[last][ADDR_W-1:2] == sb.enq_addr[ADDR_W-1:2])
                     && !(drain && (last == head));
`else
   assign coalesce = 1'b0;
`endif
   assign alloc = enq_fire & ~coalesce;

   // Walk entries oldest to youngest so the last match is the youngest store.
   always_comb begin
      found      = 1'b0;
      found_word = 1'b0;
      found_data = '0;
      idx        = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (e_valid[idx] && (e_addr[idx][ADDR_W-1:2] == sb.ld_addr[ADDR_W-1:2])) begin
            found      = 1'b1;
            found_word = is_word(e_funct[idx]);
            found_data = e_data[idx];
         end
      end
      if (enq_fire && (sb.enq_addr[ADDR_W-1:2] == sb.ld_addr[ADDR_W-1:2])) begin
         found      = 1'b1;
         found_word = is_word(sb.enq_funct);
         found_data = sb.enq_data;
      end
   end

   assign hit_cond       = found_word && (sb.ld_addr[1:0] == 2'b00);
   assign sb.ld_hit      = sb.ld_en & found & hit_cond;
   assign sb.ld_conflict = sb.ld_en & found & ~hit_cond;
   assign sb.ld_data     = sb.ld_hit ? found_data : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         e_valid <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            e_addr[i]  <= '0;
            e_data[i]  <= '0;
            e_funct[i] <= '0;
         end
      end else begin
         if (drain) begin
            e_valid[head] <= 1'b0;
            head          <= head + PTR_W'(1);
         end
         if (alloc) begin
            e_addr[tail]  <= sb.enq_addr;
            e_data[tail]  <= sb.enq_data;
            e_funct[tail] <= sb.enq_funct;
            e_valid[tail] <= 1'b1;
            tail          <= tail + PTR_W'(1);
         end
         if (coalesce) e_data[last] <= sb.enq_data;
         count <= count + CNT_W'(alloc) - CNT_W'(drain);
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes queued at enqueue, checked at drain.
`ifndef FUNC_SB
`define FUNC_SB 10'h000
`endif
`ifndef FUNC_SH
`define FUNC_SH 10'h001
`endif

module tb_store_buffer;
   localparam logic [9:0] F_SW = 10'h002;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] count;
   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [9:0]  f;
   } st_t;
   st_t exp_q[$];
   st_t pend;
   logic pend_acc;

   store_buffer_if #(.ADDR_W(32), .DATA_W(32)) sb_if ();
   store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst), .sb(sb_if.slave), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   // Memory-side scoreboard: sampled on the falling edge, ahead of the retiring rising edge.
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         st_t e;
         vectors++;
         if (int'(count) != exp_q.size() || sb_if.mem_w_en !== (exp_q.size() != 0)) begin
            miscompares++;
            $display("FAIL occupancy: count=%0d mem_w_en=%b expected count=%0d", count,
                     sb_if.mem_w_en, exp_q.size());
         end
         if (sb_if.mem_w_en === 1'b1 && sb_if.mem_ready === 1'b1 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (sb_if.mem_addr !== e.a || sb_if.mem_wdata !== e.d || sb_if.mem_funct !== e.f) begin
               miscompares++;
               $display("FAIL mem_write: got %h/%h/%h expected %h/%h/%h", sb_if.mem_addr,
                        sb_if.mem_wdata, sb_if.mem_funct, e.a, e.d, e.f);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      sb_if.enq_valid = 1'b0;
      sb_if.enq_addr  = '0;
      sb_if.enq_data  = '0;
      sb_if.enq_funct = '0;
      sb_if.mem_ready = 1'b0;
      sb_if.ld_en     = 1'b0;
      sb_if.ld_addr   = '0;
   endtask

   task automatic enq_drive(input logic [31:0] a, input logic [31:0] d, input logic [9:0] f,
                            input logic rdy);
      sb_if.enq_valid = 1'b1;
      sb_if.enq_addr  = a;
      sb_if.enq_data  = d;
      sb_if.enq_funct = f;
      sb_if.mem_ready = rdy;
      pend     = '{a: a, d: d, f: f};
      pend_acc = (exp_q.size() != DEPTH);
   endtask

   task automatic enq_commit();
      st_t b;
      logic merge;
      tick();
      sb_if.enq_valid = 1'b0;
      if (pend_acc) begin
         merge = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
         if (pend.f != `FUNC_SB && pend.f != `FUNC_SH && exp_q.size() != 0) begin
            b = exp_q[exp_q.size()-1];
            merge = (b.f != `FUNC_SB && b.f != `FUNC_SH && b.a[31:2] == pend.a[31:2]);
         end
`endif
         if (merge) begin
            b = exp_q.pop_back();
            b.d = pend.d;
            exp_q.push_back(b);
         end else begin
            exp_q.push_back(pend);
         end
      end
   endtask

   task automatic enq_cycle(input logic [31:0] a, input logic [31:0] d, input logic [9:0] f,
                            input logic rdy);
      enq_drive(a, d, f, rdy);
      #1;
      vectors++;
      if (sb_if.enq_ready !== pend_acc) begin
         miscompares++;
         $display("FAIL enq_ready: got %b expected %b", sb_if.enq_ready, pend_acc);
      end
      enq_commit();
   endtask

   task automatic drain_all();
      sb_if.mem_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      sb_if.mem_ready = 1'b0;
      vectors++;
      if (count !== 3'd0 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain_timeout: count=%0d pending=%0d expected 0", count, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_inputs();
      sb_if.ld_en = 1'b1;
      #3;
      vectors++;
      if (count !== 3'd0 || sb_if.mem_w_en !== 1'b0 || sb_if.enq_ready !== 1'b1 ||
          sb_if.mem_addr !== 32'h0 || sb_if.mem_wdata !== 32'h0 || sb_if.mem_funct !== 10'h0 ||
          sb_if.ld_hit !== 1'b0 || sb_if.ld_conflict !== 1'b0 || sb_if.ld_data !== 32'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: count=%0d w_en=%b rdy=%b hit=%b conf=%b expected 0,0,1,0,0",
                  count, sb_if.mem_w_en, sb_if.enq_ready, sb_if.ld_hit, sb_if.ld_conflict);
      end
      sb_if.ld_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_traffic();
      for (int i = 0; i < 3; i++)
         enq_cycle(32'h8000_0100 + 32'(4 * i), 32'hA000_0000 + 32'(i), F_SW, 1'b0);
      vectors++;
      if (count !== 3'd3) begin
         miscompares++;
         $display("FAIL mid_fill: count=%0d expected 3", count);
      end
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      sb_if.ld_en   = 1'b1;
      sb_if.ld_addr = 32'h8000_0100;
      #1;
      vectors++;
      if (count !== 3'd0 || sb_if.mem_w_en !== 1'b0 || sb_if.enq_ready !== 1'b1 ||
          sb_if.mem_addr !== 32'h0 || sb_if.ld_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset: count=%0d w_en=%b rdy=%b addr=%h hit=%b expected 0,0,1,0,0",
                  count, sb_if.mem_w_en, sb_if.enq_ready, sb_if.mem_addr, sb_if.ld_hit);
      end
      sb_if.ld_en = 1'b0;
      tick();
      tick();
      #1;
      rst = 1'b1;
      sb_if.mem_ready = 1'b1;
      repeat (5) tick();
      vectors++;
      if (count !== 3'd0 || sb_if.mem_w_en !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset: count=%0d w_en=%b expected 0,0", count, sb_if.mem_w_en);
      end
      sb_if.mem_ready = 1'b0;
   endtask

   task automatic test_latency_hold();
      enq_cycle(32'h8000_0010, 32'hDEAD_BEEF, F_SW, 1'b0);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (sb_if.mem_w_en !== 1'b1 || sb_if.mem_addr !== 32'h8000_0010 ||
             sb_if.mem_wdata !== 32'hDEAD_BEEF || sb_if.mem_funct !== F_SW) begin
            miscompares++;
            $display("FAIL latency_hold[%0d]: got %b/%h/%h expected 1/80000010/deadbeef", i,
                     sb_if.mem_w_en, sb_if.mem_addr, sb_if.mem_wdata);
         end
         tick();
      end
      sb_if.mem_ready = 1'b1;
      tick();
      sb_if.mem_ready = 1'b0;
      vectors++;
      if (count !== 3'd0 || sb_if.mem_w_en !== 1'b0) begin
         miscompares++;
         $display("FAIL latency_retire: count=%0d w_en=%b expected 0,0", count, sb_if.mem_w_en);
      end
   endtask

   task automatic test_full_wrap();
      for (int i = 0; i < 4; i++)
         enq_cycle(32'h8000_0200 + 32'(16 * i), 32'hB000_0000 + 32'(i), F_SW, 1'b0);
      vectors++;
      if (count !== 3'd4 || sb_if.enq_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full: count=%0d rdy=%b expected 4,0", count, sb_if.enq_ready);
      end
      enq_cycle(32'h8000_0300, 32'hC0FF_EE00, F_SW, 1'b1);
      vectors++;
      if (count !== 3'd3) begin
         miscompares++;
         $display("FAIL full_reject: count=%0d expected 3", count);
      end
      enq_cycle(32'h8000_0300, 32'hC0FF_EE01, F_SW, 1'b0);
      vectors++;
      if (count !== 3'd4) begin
         miscompares++;
         $display("FAIL wrap_accept: count=%0d expected 4", count);
      end
      drain_all();
   endtask

   task automatic test_forward();
      enq_cycle(32'h8000_0020, 32'h1111_1111, F_SW, 1'b0);
      enq_cycle(32'h8000_0020, 32'h2222_2222, F_SW, 1'b0);
      sb_if.ld_en   = 1'b1;
      sb_if.ld_addr = 32'h8000_0020;
      #1;
      vectors++;
      if (sb_if.ld_hit !== 1'b1 || sb_if.ld_conflict !== 1'b0 || sb_if.ld_data !== 32'h2222_2222) begin
         miscompares++;
         $display("FAIL fwd_youngest: hit=%b conf=%b data=%h expected 1,0,22222222",
                  sb_if.ld_hit, sb_if.ld_conflict, sb_if.ld_data);
      end
      sb_if.ld_addr = 32'h8000_0024;
      #1;
      vectors++;
      if (sb_if.ld_hit !== 1'b0 || sb_if.ld_conflict !== 1'b0 || sb_if.ld_data !== 32'h0) begin
         miscompares++;
         $display("FAIL fwd_miss: hit=%b conf=%b data=%h expected 0,0,0",
                  sb_if.ld_hit, sb_if.ld_conflict, sb_if.ld_data);
      end
      sb_if.ld_addr = 32'h8000_0022;
      #1;
      vectors++;
      if (sb_if.ld_hit !== 1'b0 || sb_if.ld_conflict !== 1'b1) begin
         miscompares++;
         $display("FAIL fwd_misaligned: hit=%b conf=%b expected 0,1", sb_if.ld_hit, sb_if.ld_conflict);
      end
      sb_if.ld_en   = 1'b0;
      sb_if.ld_addr = 32'h8000_0020;
      #1;
      vectors++;
      if (sb_if.ld_hit !== 1'b0 || sb_if.ld_conflict !== 1'b0 || sb_if.ld_data !== 32'h0) begin
         miscompares++;
         $display("FAIL fwd_ld_off: hit=%b conf=%b data=%h expected 0,0,0",
                  sb_if.ld_hit, sb_if.ld_conflict, sb_if.ld_data);
      end
      sb_if.ld_en = 1'b1;
      enq_drive(32'h8000_0020, 32'h3333_3333, F_SW, 1'b0);
      #1;
      vectors++;
      if (sb_if.ld_hit !== 1'b1 || sb_if.ld_data !== 32'h3333_3333) begin
         miscompares++;
         $display("FAIL fwd_same_cycle: hit=%b data=%h expected 1,33333333", sb_if.ld_hit, sb_if.ld_data);
      end
      enq_commit();
      sb_if.ld_en = 1'b0;
      drain_all();
   endtask

   task automatic test_conflict();
      enq_cycle(32'h8000_0031, 32'h0000_00AB, `FUNC_SB, 1'b0);
      sb_if.ld_en   = 1'b1;
      sb_if.ld_addr = 32'h8000_0030;
      for (int i = 0; i < 2; i++) begin
         #1;
         vectors++;
         if (sb_if.ld_conflict !== 1'b1 || sb_if.ld_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL conflict_hold[%0d]: conf=%b hit=%b expected 1,0", i,
                     sb_if.ld_conflict, sb_if.ld_hit);
         end
         tick();
      end
      sb_if.mem_ready = 1'b1;
      #1;
      vectors++;
      if (sb_if.ld_conflict !== 1'b1) begin
         miscompares++;
         $display("FAIL conflict_retiring: conf=%b expected 1", sb_if.ld_conflict);
      end
      tick();
      sb_if.mem_ready = 1'b0;
      vectors++;
      if (sb_if.ld_conflict !== 1'b0 || sb_if.ld_hit !== 1'b0) begin
         miscompares++;
         $display("FAIL conflict_clear: conf=%b hit=%b expected 0,0", sb_if.ld_conflict, sb_if.ld_hit);
      end
      sb_if.ld_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [6] = '{32'h8000_0500, 32'h8000_0504, 32'h8000_0504,
                                 32'h8000_0508, 32'h8000_050C, 32'h8000_0510};
      for (int i = 0; i < 6; i++) begin
         enq_cycle(addrs[i], 32'hD000_0000 + 32'(i), (i == 3) ? `FUNC_SH : F_SW, 1'b1);
         vectors++;
         if (count !== 3'd1) begin
            miscompares++;
            $display("FAIL b2b_count[%0d]: count=%0d expected 1", i, count);
         end
      end
      drain_all();
   endtask

   task automatic test_coalesce();
      enq_cycle(32'h8000_0040, 32'h0000_0001, F_SW, 1'b0);
      enq_cycle(32'h8000_0040, 32'h0000_0002, F_SW, 1'b0);
      vectors++;
`ifdef STORE_BUF_COALESCE_EN
      if (count !== 3'd1 || sb_if.mem_wdata !== 32'h2) begin
         miscompares++;
         $display("FAIL coalesce: count=%0d wdata=%h expected 1,2", count, sb_if.mem_wdata);
      end
`else
      if (count !== 3'd2 || sb_if.mem_wdata !== 32'h1) begin
         miscompares++;
         $display("FAIL no_coalesce: count=%0d wdata=%h expected 2,1", count, sb_if.mem_wdata);
      end
`endif
      drain_all();
   endtask

   initial begin
      test_reset();
      test_reset_mid_traffic();
      test_latency_hold();
      test_full_wrap();
      test_forward();
      test_conflict();
      test_back_to_back();
      test_coalesce();
      tick();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL leftover: pending=%0d expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
